// File: rtl/path_delay_spy_ctrl_if.sv
// ---------------------------------------------------------------------------
// path_delay_spy_ctrl_if
//
// Purpose : groups the control, configuration, path-probe and status signals
//           of path_delay_spy_ctrl into one bundle. clk and rst stay outside
//           as plain scalar ports on the controller.
//
// Signals (direction seen from the controller, modport slave):
//   start          in   begin a measurement run (honoured only when idle)
//   abort          in   terminate the run in progress
//   num_trials     in   number of launch/capture trials in a run
//   settle_cycles  in   quiet cycles before each launch (0 behaves as 1)
//   sample_cycles  in   cycles from launch to capture (0 behaves as 1)
//   expect_inv     in   1: path output is the inverse of the path input
//   arm_trigger    in   1: hold the trojan trigger inputs active while busy
//   path_out       in   monitored path endpoint (same clock domain)
//   path_in        out  registered stimulus driving the path source
//   ht_in1/ht_in2  out  trojan trigger inputs
//   busy           out  run in progress
//   done           out  one-cycle pulse at run completion
//   trial_count    out  completed trials
//   err_count      out  mismatching trials (saturating)
//   first_fail     out  1-based index of first mismatching trial, 0 if none
//
// Modports: master = stimulus/host side, slave = controller side.
// ---------------------------------------------------------------------------
interface path_delay_spy_ctrl_if #(
  parameter int CNT_W = 16
);

  logic             start;
  logic             abort;
  logic [CNT_W-1:0] num_trials;
  logic [7:0]       settle_cycles;
  logic [7:0]       sample_cycles;
  logic             expect_inv;
  logic             arm_trigger;
  logic             path_out;

  logic             path_in;
  logic             ht_in1;
  logic             ht_in2;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] trial_count;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] first_fail;

  modport master (
    output start, abort, num_trials, settle_cycles, sample_cycles,
           expect_inv, arm_trigger, path_out,
    input  path_in, ht_in1, ht_in2, busy, done,
           trial_count, err_count, first_fail
  );

  modport slave (
    input  start, abort, num_trials, settle_cycles, sample_cycles,
           expect_inv, arm_trigger, path_out,
    output path_in, ht_in1, ht_in2, busy, done,
           trial_count, err_count, first_fail
  );

endinterface

// File: rtl/path_delay_spy_ctrl.sv
// ---------------------------------------------------------------------------
// path_delay_spy_ctrl
//
// Purpose : measures whether a combinational path settles within a chosen
//           number of cycles. Each trial waits a quiet period, toggles the
//           path source (path_in), waits sample_cycles, captures the path
//           endpoint (path_out) and compares it with the value the path
//           should produce. Trial and mismatch counts plus the index of the
//           first failing trial are reported. While a run is in progress the
//           trojan trigger inputs can optionally be held active so that a
//           triggered payload's extra delay shows up as mismatches.
//
// Ports   :
//   clk   in   single clock, all state changes on the rising edge
//   rst   in   asynchronous, active-high reset
//   bus   slave modport of path_delay_spy_ctrl_if (see that file)
//
// Parameters:
//   CNT_W  width of trial_count / err_count / first_fail / num_trials
//
// Sequence per trial: SETTLE (max(settle,1)) -> LAUNCH (1) ->
//   WAIT (max(sample,1)) -> CHECK (1); after the last trial DONE (1).
// ---------------------------------------------------------------------------
module path_delay_spy_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  path_delay_spy_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_LAUNCH,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  // Configuration captured when a run is accepted.
  logic [CNT_W-1:0] num_trials_q;
  logic [7:0]       settle_q;
  logic [7:0]       sample_q;
  logic             expect_inv_q;
  logic             arm_q;

  // Datapath.
  logic [7:0]       timer;
  logic             path_in_q;
  logic             captured;
  logic [CNT_W-1:0] trial_q;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] first_q;

  // Derived terms.
  logic             busy_int;
  logic             timer_zero;
  logic [CNT_W-1:0] trial_next;
  logic             mismatch;
  logic             last_trial;

  // Dwell states last max(cycles,1); the timer counts down to zero from the
  // loaded value, so it is loaded with one less than the dwell length.
  function automatic logic [7:0] dwell_load(input logic [7:0] cycles);
    return (cycles == 8'd0) ? 8'd0 : cycles - 8'd1;
  endfunction

  assign busy_int   = (state == S_SETTLE) || (state == S_LAUNCH) ||
                      (state == S_WAIT)   || (state == S_CHECK);
  assign timer_zero = (timer == 8'd0);
  assign trial_next = trial_q + CNT_ONE;
  // In CHECK path_in already holds the launched value, so the settled path
  // endpoint must equal it (or its inverse for an inverting path).
  assign mismatch   = captured != (path_in_q ^ expect_inv_q);
  assign last_trial = (trial_next == num_trials_q);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. Abort is only meaningful in the busy states and takes
  // priority over every other transition there, including the CHECK update.
  // -------------------------------------------------------------------------
  // NOTE: the default assignment first keeps this block free of latches on
  // any path that does not explicitly assign state_nxt.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          // The raw input is used here because it is being latched on this
          // same edge; a zero-trial run skips straight to DONE.
          state_nxt = (bus.num_trials == CNT_ZERO) ? S_DONE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (bus.abort)       state_nxt = S_IDLE;
        else if (timer_zero) state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        if (bus.abort) state_nxt = S_IDLE;
        else           state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.abort)       state_nxt = S_IDLE;
        else if (timer_zero) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (bus.abort)       state_nxt = S_IDLE;
        else if (last_trial) state_nxt = S_DONE;
        else                 state_nxt = S_SETTLE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Configuration latch, dwell timer, stimulus and result counters.
  // An abort leaves every register as it is; the FSM simply returns to IDLE.
  // -------------------------------------------------------------------------
  // NOTE: the configuration registers are reset along with everything else
  // so the trigger outputs and comparison polarity are never unknown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_trials_q <= '0;
      settle_q     <= '0;
      sample_q     <= '0;
      expect_inv_q <= 1'b0;
      arm_q        <= 1'b0;
      timer        <= '0;
      path_in_q    <= 1'b0;
      captured     <= 1'b0;
      trial_q      <= '0;
      err_q        <= '0;
      first_q      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            num_trials_q <= bus.num_trials;
            settle_q     <= bus.settle_cycles;
            sample_q     <= bus.sample_cycles;
            expect_inv_q <= bus.expect_inv;
            arm_q        <= bus.arm_trigger;
            timer        <= dwell_load(bus.settle_cycles);
            trial_q      <= '0;
            err_q        <= '0;
            first_q      <= '0;
          end
        end
        S_SETTLE: begin
          if (!bus.abort && !timer_zero) begin
            timer <= timer - 8'd1;
          end
        end
        S_LAUNCH: begin
          if (!bus.abort) begin
            path_in_q <= ~path_in_q;
            timer     <= dwell_load(sample_q);
          end
        end
        S_WAIT: begin
          if (!bus.abort) begin
            if (timer_zero) begin
              captured <= bus.path_out;
            end else begin
              timer <= timer - 8'd1;
            end
          end
        end
        S_CHECK: begin
          if (!bus.abort) begin
            trial_q <= trial_next;
            timer   <= dwell_load(settle_q);
            if (mismatch) begin
              if (err_q != CNT_MAX) begin
                err_q <= err_q + CNT_ONE;
              end
              if (first_q == CNT_ZERO) begin
                first_q <= trial_next;
              end
            end
          end
        end
        default: begin
          // DONE: results are held until the next accepted start.
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded from registers only, so all read 0 as soon as reset is
  // asserted.
  // -------------------------------------------------------------------------
  assign bus.path_in     = path_in_q;
  assign bus.busy        = busy_int;
  assign bus.done        = (state == S_DONE);
  assign bus.ht_in1      = busy_int & arm_q;
  assign bus.ht_in2      = busy_int & arm_q;
  assign bus.trial_count = trial_q;
  assign bus.err_count   = err_q;
  assign bus.first_fail  = first_q;

endmodule

// File: tb/tb_path_delay_spy_ctrl.sv
// ---------------------------------------------------------------------------
// tb_path_delay_spy_ctrl
//
// Self-checking bench for path_delay_spy_ctrl. A table of run descriptions
// (configuration, how path_out responds, expected latency and results) is
// applied in order; expected results go into a scoreboard queue when a run
// is started and are popped when done is seen. Hand-written sequences cover
// abort mid-run, start while busy, abort while idle and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_path_delay_spy_ctrl;

  localparam int CNT_W = 16;

  // How the bench drives path_out.
  localparam logic [1:0] M_INV    = 2'd0; // path_out = ~path_in
  localparam logic [1:0] M_FOLLOW = 2'd1; // path_out =  path_in
  localparam logic [1:0] M_STUCK0 = 2'd2; // path_out = 0
  localparam logic [1:0] M_STUCK1 = 2'd3; // path_out = 1

  typedef struct {
    logic [CNT_W-1:0] n;
    logic [7:0]       settle;
    logic [7:0]       sample;
    logic             inv;
    logic             arm;
    logic [1:0]       mode;
    int               cycles;   // edges from start edge to first done cycle
    logic [CNT_W-1:0] trials;
    logic [CNT_W-1:0] errs;
    logic [CNT_W-1:0] first;
    logic             pin_end;
  } vec_t;

  typedef struct {
    logic [CNT_W-1:0] trials;
    logic [CNT_W-1:0] errs;
    logic [CNT_W-1:0] first;
    logic             pin;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [1:0] out_mode;

  int n_cmp  = 0;
  int n_fail = 0;

  exp_t sb[$];
  vec_t tbl[7];

  path_delay_spy_ctrl_if #(.CNT_W(CNT_W)) bus ();

  path_delay_spy_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.path_out = (out_mode == M_INV)    ? ~bus.path_in :
                        (out_mode == M_FOLLOW) ?  bus.path_in :
                        (out_mode == M_STUCK1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_path_in"},     bus.path_in,     0);
    check({tag, "_ht_in1"},      bus.ht_in1,      0);
    check({tag, "_ht_in2"},      bus.ht_in2,      0);
    check({tag, "_busy"},        bus.busy,        0);
    check({tag, "_done"},        bus.done,        0);
    check({tag, "_trial_count"}, bus.trial_count, 0);
    check({tag, "_err_count"},   bus.err_count,   0);
    check({tag, "_first_fail"},  bus.first_fail,  0);
  endtask

  // Start one run, scramble the configuration inputs afterwards (the run
  // must use the latched copy), check busy/trigger every cycle and the
  // results when done appears.
  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    int   k;
    bit   seen;
    out_mode          = v.mode;
    bus.num_trials    = v.n;
    bus.settle_cycles = v.settle;
    bus.sample_cycles = v.sample;
    bus.expect_inv    = v.inv;
    bus.arm_trigger   = v.arm;
    bus.start         = 1'b1;
    e = '{v.trials, v.errs, v.first, v.pin_end};
    sb.push_back(e);
    tick();
    bus.start         = 1'b0;
    bus.num_trials    = v.n + CNT_W'(3);
    bus.settle_cycles = v.settle + 8'd4;
    bus.sample_cycles = ~v.sample;
    bus.expect_inv    = ~v.inv;
    bus.arm_trigger   = ~v.arm;
    seen = 1'b0;
    k    = 1;
    while (!seen && k <= v.cycles + 4) begin
      check({tag, "_busy"},   bus.busy,   k < v.cycles);
      check({tag, "_ht_in1"}, bus.ht_in1, v.arm && (k < v.cycles));
      check({tag, "_ht_in2"}, bus.ht_in2, v.arm && (k < v.cycles));
      if (bus.done) begin
        seen = 1'b1;
        check({tag, "_latency"}, k, v.cycles);
        e = sb.pop_front();
        check({tag, "_trial_count"}, bus.trial_count, e.trials);
        check({tag, "_err_count"},   bus.err_count,   e.errs);
        check({tag, "_first_fail"},  bus.first_fail,  e.first);
        check({tag, "_path_in"},     bus.path_in,     e.pin);
      end else begin
        tick();
        k++;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_done_timeout: got no done expected done at cycle %0d",
               tag, v.cycles);
      e = sb.pop_front();
    end
    // done is a single pulse and the results stay put afterwards.
    tick();
    check({tag, "_done_pulse"}, bus.done, 0);
    check({tag, "_idle_busy"},  bus.busy, 0);
    tick();
    tick();
    check({tag, "_hold_trials"}, bus.trial_count, v.trials);
    check({tag, "_hold_errs"},   bus.err_count,   v.errs);
  endtask

  initial begin
    int  done_seen;
    // Run table. path_in carries over between runs:
    //  v0: 4 trials, inverting path, always correct; path_in 0 -> 0.
    //  v1: minimal dwell (settle=sample=0 act as 1): 5 cycles; path_in 0 -> 1.
    //  v2: path_out stuck 0, non-inverting. path_in enters at 1, so trials
    //      launch 0,1,0,1 and trials 2 and 4 mismatch; path_in ends at 1.
    //  v3: zero trials: done on the first cycle after start, path_in held.
    //  v4: armed run, stuck 1, inverting: launches 0,1,0 -> trial 2 fails.
    //  v5: follow path but expect inversion: every trial fails; 1 -> 0... ->0.
    //  v6: first run after reset: path_in starts at 0 and ends at 1.
    tbl[0] = '{16'd4,  8'd2, 8'd3, 1'b1, 1'b0, M_INV,    29, 16'd4, 16'd0, 16'd0, 1'b0};
    tbl[1] = '{16'd1,  8'd0, 8'd0, 1'b0, 1'b0, M_FOLLOW,  5, 16'd1, 16'd0, 16'd0, 1'b1};
    tbl[2] = '{16'd4,  8'd2, 8'd3, 1'b0, 1'b0, M_STUCK0, 29, 16'd4, 16'd2, 16'd2, 1'b1};
    tbl[3] = '{16'd0,  8'd5, 8'd5, 1'b0, 1'b1, M_INV,     1, 16'd0, 16'd0, 16'd0, 1'b1};
    tbl[4] = '{16'd3,  8'd1, 8'd2, 1'b1, 1'b1, M_STUCK1, 16, 16'd3, 16'd1, 16'd2, 1'b0};
    tbl[5] = '{16'd2,  8'd3, 8'd1, 1'b1, 1'b0, M_FOLLOW, 13, 16'd2, 16'd2, 16'd1, 1'b0};
    tbl[6] = '{16'd1,  8'd0, 8'd0, 1'b0, 1'b0, M_FOLLOW,  5, 16'd1, 16'd0, 16'd0, 1'b1};

    out_mode          = M_INV;
    bus.start         = 1'b0;
    bus.abort         = 1'b0;
    bus.num_trials    = '0;
    bus.settle_cycles = '0;
    bus.sample_cycles = '0;
    bus.expect_inv    = 1'b0;
    bus.arm_trigger   = 1'b0;
    rst               = 1'b1;

    // Reset state, observed before any clock edge.
    #2;
    check_all_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Abort in the first WAIT cycle of trial 3 of 10 (5 cycles per trial:
    // SETTLE, LAUNCH, WAIT, WAIT, CHECK), with a stray start mid-run.
    out_mode          = M_INV;
    bus.num_trials    = 16'd10;
    bus.settle_cycles = 8'd1;
    bus.sample_cycles = 8'd2;
    bus.expect_inv    = 1'b1;
    bus.arm_trigger   = 1'b1;
    bus.start         = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k < 13; k++) begin
      bus.start = (k == 7);
      tick();
    end
    bus.start = 1'b0;
    check("abort_pre_busy",   bus.busy,        1);
    check("abort_pre_ht_in1", bus.ht_in1,      1);
    check("abort_pre_trials", bus.trial_count, 2);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy",    bus.busy,        0);
    check("abort_done",    bus.done,        0);
    check("abort_ht_in1",  bus.ht_in1,      0);
    check("abort_ht_in2",  bus.ht_in2,      0);
    check("abort_trials",  bus.trial_count, 2);
    check("abort_errs",    bus.err_count,   0);
    check("abort_path_in", bus.path_in,     1);
    done_seen = 0;
    for (int k = 0; k < 15; k++) begin
      if (bus.done || bus.busy) done_seen++;
      tick();
    end
    check("abort_stays_idle", done_seen, 0);

    // Abort held in IDLE does not block a start; then reset mid-run.
    // 6 cycles per trial; after 10 edges trial 2 has just launched.
    bus.num_trials    = 16'd3;
    bus.settle_cycles = 8'd2;
    bus.sample_cycles = 8'd2;
    bus.expect_inv    = 1'b1;
    bus.arm_trigger   = 1'b1;
    bus.abort         = 1'b1;
    bus.start         = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check("idle_abort_busy", bus.busy, 1);
    for (int k = 1; k < 10; k++) tick();
    check("rst_pre_trials",  bus.trial_count, 1);
    check("rst_pre_path_in", bus.path_in,     1);
    check("rst_pre_ht_in2",  bus.ht_in2,      1);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    #1;
    rst = 1'b0;
    tick();
    check("post_rst_busy", bus.busy, 0);

    run_vec(tbl[6], "post_rst");

    check("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
